wasm_leb128_decoder: RTL
========================

# wasm_leb128_decoder

Streaming LEB128 immediate decoder sitting between the instruction memory controller and the instruction decoder inside `WASM_TOP`. It accepts one instruction byte per handshake, accumulates a 1–5 byte unsigned or signed LEB128 field, and returns a 32-bit value, its encoded length and an encoding-error flag. The instruction decoder starts it after an opcode that carries an immediate: `i32.const` uses signed mode; `local.get`, `call` and `br` indices use unsigned mode.

## Interface
- `MAX_BYTES`, 5, maximum encoded length of a 32-bit field; fixed at 5 for this revision.
- `i_clk`  in  1  single clock; all state changes on rising edge.
- `i_rst_n`  in  1  reset is synchronous and active-low.
- `i_start`  in  1  start a decode; honoured only in IDLE.
- `i_signed`  in  1  sampled with `i_start`: 1 = signed LEB128, 0 = unsigned.
- `i_byte_valid`  in  1  `i_byte` holds a valid instruction byte.
- `i_byte`  in  8  instruction byte from the memory controller.
- `o_byte_ready`  out  1  decoder accepts `i_byte` this cycle.
- `o_busy`  out  1  state is not IDLE.
- `o_val_valid`  out  1  result beat valid.
- `o_value`  out  32  decoded value.
- `o_len`  out  3  number of bytes consumed, 1–5.
- `o_err`  out  1  encoding error; qualified by `o_val_valid`.
- `i_val_ready`  in  1  consumer accepts the result beat.

## Operation
- States: IDLE, COLLECT, DONE.
- IDLE:
  - `i_start`=1 latches `i_signed`, clears the accumulator, count and error, and moves to COLLECT.
- COLLECT:
  - `o_byte_ready`=1.
  - A byte is accepted when `i_byte_valid` && `o_byte_ready`.
  - Each accepted byte k (0-based) ORs `i_byte[6:0]` into accumulator bits [7k+6:7k]. Bits beyond 31 are discarded, and count increments.
- Termination, on an accepted byte with bit 7 = 0:
  - Go to DONE.
  - If signed, length < 5 and `i_byte[6]`=1, set accumulator bits [31:7*len] to 1. Length 5 is never sign-extended.
- Fifth byte (k=4) checks:
  - Unsigned: `i_byte[6:4]` must be 000.
  - Signed: `i_byte[6:4]` must equal three copies of `i_byte[3]`.
  - Bit 7 must be 0.
  - Any violation sets error and forces DONE on that byte, with `o_len`=5.
  - No byte after the fifth is ever consumed.
- DONE:
  - `o_val_valid`=1 and `o_byte_ready`=0.
  - `o_value`, `o_len` and `o_err` are stable until the handshake.
  - On error, `o_value` is the raw accumulated low 32 bits.
  - On `o_val_valid` && `i_val_ready`, go to IDLE.
- `i_start` outside IDLE is ignored, with no effect on the decode in progress.
- `i_byte` when `o_byte_ready`=0 is not consumed; the upstream holds it.

## Timing
- Reset (`i_rst_n`=0 at a rising edge) puts the block in IDLE.
- Output values after reset: `o_byte_ready`=0, `o_busy`=0, `o_val_valid`=0, `o_value`=0, `o_len`=0, `o_err`=0.
- Reset mid-COLLECT or mid-DONE discards the partial result. No beat is emitted afterwards.
- `o_byte_ready` and `o_busy` are decoded from the state register, so they assert the cycle after `i_start`.
- Latency: the result beat is valid the cycle after the terminating byte's handshake. With no bubbles, an N-byte field takes N+1 cycles from the `i_start` edge to `o_val_valid`.
- Bubbles (`i_byte_valid`=0) stall COLLECT with no state change.
- Output back-pressure (`i_val_ready`=0) holds DONE indefinitely.
- Back-to-back decodes: the handshake cycle returns to IDLE, and the next `i_start` can be taken on the following cycle. Minimum issue interval is N+2 cycles.
- `o_busy` falls the cycle after the result handshake.

## Test plan
- Unsigned `E5 8E 26`, no bubbles, `i_val_ready`=1:
  - `o_value`=0x00098765 (624485), `o_len`=3, `o_err`=0.
  - `o_val_valid` asserts 4 cycles after `i_start`.
- Signed `C0 BB 78` → `o_value`=0xFFFE1DC0 (−123456), `o_len`=3.
- Single byte `7F`:
  - Signed → 0xFFFFFFFF, `o_len`=1.
  - Unsigned → 0x0000007F, `o_len`=1.
  - Signed `3F` → 0x0000003F.
- Five-byte limits:
  - Unsigned `FF FF FF FF 0F` → 0xFFFFFFFF, `o_len`=5, `o_err`=0.
  - Unsigned `FF FF FF FF 1F` → `o_err`=1.
  - Signed `80 80 80 80 78` → 0x80000000, `o_err`=0.
  - Signed `80 80 80 80 08` → `o_err`=1.
- Overlong `80 80 80 80 80 00`:
  - `o_err`=1, `o_len`=5.
  - The sixth byte stays unconsumed: `o_byte_ready`=0 while it is presented.
- Robustness:
  - Random `i_byte_valid` gaps and `i_val_ready` held low 3 cycles give identical results to the no-bubble cases.
  - `i_start` pulsed in COLLECT is ignored.
  - `i_rst_n` low after byte 2 of a 3-byte field gives all outputs 0 next cycle.
  - A following decode of `05` returns 5.

Source files
------------

// File: rtl/wasm_leb128_decoder.sv
// Streaming LEB128 immediate decoder.
// Takes one instruction byte per handshake and accumulates a 1-5 byte
// unsigned or signed LEB128 field. Returns a 32-bit value, the encoded
// length and an encoding-error flag as a single result beat.
module wasm_leb128_decoder #(
  parameter int MAX_BYTES = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_signed,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_byte_ready,
  output logic        o_busy,
  output logic        o_val_valid,
  output logic [31:0] o_value,
  output logic [2:0]  o_len,
  output logic        o_err,
  input  logic        i_val_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        signed_q, signed_d;
  logic [31:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic        byte_fire;
  logic [5:0]  byte_shamt;
  logic [31:0] byte_bits;
  logic [31:0] acc_merged;
  logic [2:0]  len_next;
  logic [5:0]  ext_shamt;
  logic [31:0] ext_mask;
  logic        last_slot;
  logic        top_bad;

  // Per-byte datapath: place the 7 payload bits of the incoming byte at
  // its group position, and prepare the sign-extension mask and the
  // fifth-byte range check in case this byte ends the field.
  always_comb begin
    byte_fire  = i_byte_valid && (state_q == COLLECT);
    byte_shamt = {3'b000, cnt_q} * 6'd7;
    byte_bits  = 32'(i_byte[6:0]) << byte_shamt;
    acc_merged = acc_q | byte_bits;
    len_next   = cnt_q + 3'd1;
    ext_shamt  = {3'b000, len_next} * 6'd7;
    ext_mask   = 32'hFFFF_FFFF << ext_shamt;
    last_slot  = (cnt_q == 3'(MAX_BYTES - 1));
    if (signed_q) begin
      top_bad = (i_byte[6:4] != {3{i_byte[3]}});
    end else begin
      top_bad = (i_byte[6:4] != 3'b000);
    end
  end

  // Next-state and accumulator update for the IDLE/COLLECT/DONE sequence.
  always_comb begin
    state_d  = state_q;
    signed_d = signed_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          signed_d = i_signed;
          acc_d    = 32'd0;
          cnt_d    = 3'd0;
          err_d    = 1'b0;
          state_d  = COLLECT;
        end
      end
      COLLECT: begin
        if (byte_fire) begin
          acc_d = acc_merged;
          cnt_d = len_next;
          if (last_slot) begin
            // The fifth byte always ends the field; it is never
            // sign-extended, and out-of-range or continued encodings
            // are flagged while keeping the raw bits.
            state_d = DONE;
            if (top_bad || i_byte[7]) begin
              err_d = 1'b1;
            end
          end else if (!i_byte[7]) begin
            state_d = DONE;
            if (signed_q && i_byte[6]) begin
              acc_d = acc_merged | ext_mask;
            end
          end
        end
      end
      DONE: begin
        if (i_val_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      signed_q <= 1'b0;
      acc_q    <= 32'd0;
      cnt_q    <= 3'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      signed_q <= signed_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign o_byte_ready = (state_q == COLLECT);
  assign o_busy       = (state_q != IDLE);
  assign o_val_valid  = (state_q == DONE);
  assign o_value      = acc_q;
  assign o_len        = cnt_q;
  assign o_err        = err_q;

endmodule
